// File: rtl/atom_npu_mac_sched.sv
// Round-robin scheduler sharing one serial multiplier core among NREQ requesters,
// with a watchdog that aborts jobs the core never completes.
//
// state | meaning
// IDLE  | waiting for en && a request; arbitrate and latch operands
// ISSUE | single-cycle start pulse to the core; watchdog cleared
// WAIT  | operands held; wait for core done or watchdog expiry
// RESP  | ack/resp_valid pulse to the granted requester
module atom_npu_mac_sched #(
   parameter int NREQ    = 4,
   parameter int DW      = 4,
   parameter int TIMEOUT = 16,
   localparam int IDW    = $clog2(NREQ),
   localparam int CW     = $clog2(TIMEOUT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DW-1:0]   req_a,
   input  logic [NREQ*DW-1:0]   req_w,
   output logic [NREQ-1:0]      ack,
   output logic                 resp_valid,
   output logic [DW-1:0]        resp_data,
   output logic                 resp_err,
   output logic [IDW-1:0]       resp_id,
   output logic                 busy,
   output logic                 mul_start,
   output logic [DW-1:0]        mul_a,
   output logic [DW-1:0]        mul_w,
   input  logic [DW-1:0]        mul_result,
   input  logic                 mul_done
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t          state;
   state_t          state_nxt;
   logic [IDW-1:0]  last;
   logic [IDW-1:0]  id;
   logic [CW-1:0]   cnt;
   logic            gnt_found;
   logic [IDW-1:0]  gnt_id;
   logic            expired;

   // Scan starts one past the last served requester, wrapping at NREQ.
   always_comb begin
      int s;
      gnt_found = 1'b0;
      gnt_id    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         s = int'(last) + k;
         if (s >= NREQ) s = s - NREQ;
         if (!gnt_found && req[IDW'(s)]) begin
            gnt_found = 1'b1;
            gnt_id    = IDW'(s);
         end
      end
   end

   assign expired = (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (en && gnt_found) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (mul_done || expired) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Response fields are loaded only when leaving WAIT so they hold between jobs.
   always_ff @(posedge clk) begin
      if (rst) begin
         last      <= IDW'(NREQ - 1);
         id        <= '0;
         cnt       <= '0;
         mul_a     <= '0;
         mul_w     <= '0;
         resp_data <= '0;
         resp_err  <= 1'b0;
         resp_id   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (en && gnt_found) begin
                  id    <= gnt_id;
                  mul_a <= req_a[gnt_id*DW +: DW];
                  mul_w <= req_w[gnt_id*DW +: DW];
               end
            end
            S_ISSUE: cnt <= '0;
            S_WAIT: begin
               if (mul_done) begin
                  resp_data <= mul_result;
                  resp_err  <= 1'b0;
                  resp_id   <= id;
               end else if (expired) begin
                  resp_data <= '0;
                  resp_err  <= 1'b1;
                  resp_id   <= id;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RESP: last <= id;
            default: ;
         endcase
      end
   end

   always_comb begin
      ack        = '0;
      resp_valid = 1'b0;
      mul_start  = 1'b0;
      busy       = (state != S_IDLE);
      case (state)
         S_ISSUE: mul_start = 1'b1;
         S_RESP: begin
            resp_valid = 1'b1;
            ack[id]    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
